usb_rx_bit_timer: RTL and testbench

//   Receive-side bit timing for the USB transceiver. Recovers the bit clock from the

---
 rtl/usb_rx_bit_timer_if.sv | 23 ++
 rtl/usb_rx_bit_timer.sv | 93 +++++++++
 tb/tb_usb_rx_bit_timer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/usb_rx_bit_timer_if.sv
// rtl/usb_rx_bit_timer_if.sv - RX bit-timer handshake bundle between unstuffer, timer and RX FSM
interface usb_rx_bit_timer_if #(
  parameter int BITS_PER_BYTE = 8
);
  localparam int CW = $clog2(BITS_PER_BYTE + 1);

  logic          rcving;
  logic          d_edge;
  logic          stuff_bit;
  logic          shift_enable;
  logic          byte_received;
  logic [CW-1:0] bit_count;

  modport master (
    output rcving, d_edge, stuff_bit,
    input  shift_enable, byte_received, bit_count
  );

  modport slave (
    input  rcving, d_edge, stuff_bit,
    output shift_enable, byte_received, bit_count
  );
endinterface

// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - USB RX bit clock recovery, mid-bit shift strobe and byte counting
// Optional feature: USB_RX_EDGE_RESYNC_EN re-aligns the phase on every line edge while receiving.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_bit_timer_if.slave  bt
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(BITS_PER_BYTE + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BITS_PER_BYTE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_ph;
  logic [CW-1:0] r_bit_count;
  logic          r_byte_received;
  logic          w_shift;
  logic          w_count;
  logic          w_run_resync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bt.rcving) w_next = S_ARM;
      S_ARM:   if (!bt.rcving) w_next = S_IDLE;
               else if (bt.d_edge) w_next = S_RUN;
      S_RUN:   if (!bt.rcving) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift         = (r_state == S_RUN) && (r_ph == PH_SAMPLE);
    bt.shift_enable = w_shift;
  end

`ifdef USB_RX_EDGE_RESYNC_EN
  assign w_run_resync = bt.d_edge;
`else
  assign w_run_resync = 1'b0;
`endif

  assign w_count = w_shift && !bt.stuff_bit;

  // Outside RUN the phase sits at 0, so the ARM->RUN transition starts aligned to the first edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ph <= '0;
    end else if (w_next != S_RUN || r_state != S_RUN || w_run_resync) begin
      r_ph <= '0;
    end else if (r_ph == PH_LAST) begin
      r_ph <= '0;
    end else begin
      r_ph <= r_ph + 1'b1;
    end
  end

  // Leaving RUN discards the partial byte, even when the final counting shift lands that cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_count     <= '0;
      r_byte_received <= 1'b0;
    end else begin
      r_byte_received <= 1'b0;
      if (w_next != S_RUN) begin
        r_bit_count <= '0;
      end else if (w_count) begin
        if (r_bit_count == CNT_LAST) begin
          r_bit_count     <= '0;
          r_byte_received <= 1'b1;
        end else begin
          r_bit_count <= r_bit_count + 1'b1;
        end
      end
    end
  end

  assign bt.byte_received = r_byte_received;
  assign bt.bit_count     = r_bit_count;
endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb/tb_usb_rx_bit_timer.sv - self-checking bench for usb_rx_bit_timer against a timing-rule model
module tb_usb_rx_bit_timer;
  localparam int CPB = 8;
  localparam int SP  = 3;
  localparam int BPB = 8;
`ifdef USB_RX_EDGE_RESYNC_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_bit_timer_if #(.BITS_PER_BYTE(BPB)) bus ();

  usb_rx_bit_timer #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_PHASE (SP),
    .BITS_PER_BYTE(BPB)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bt   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int base  = 0;
  int obs_max = 0;
  int shift_q[$];
  int byte_q[$];

  // Model: packet mode, cycle of last alignment edge, counted bits, pending byte pulse
  int m_mode  = 0;
  int m_align = 0;
  int m_cnt   = 0;
  bit m_bpend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0d exp=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_align = 0; m_cnt = 0; m_bpend = 1'b0;
  endtask

  task automatic cyc(input bit rcv, input bit edg, input bit stf);
    bit exp_se;
    bit nb;
    bus.rcving = rcv; bus.d_edge = edg; bus.stuff_bit = stf;
    @(negedge clk);
    exp_se = (m_mode == 2) && (((t - m_align - 1) % CPB) == SP);
    check("shift_enable", {31'd0, bus.shift_enable}, {31'd0, exp_se});
    check("byte_received", {31'd0, bus.byte_received}, {31'd0, m_bpend});
    check("bit_count", 32'(bus.bit_count), 32'(m_cnt));
    if (bus.shift_enable === 1'b1) shift_q.push_back(t - base);
    if (bus.byte_received === 1'b1) byte_q.push_back(t - base);
    if (int'(bus.bit_count) > obs_max) obs_max = int'(bus.bit_count);
    nb = 1'b0;
    case (m_mode)
      0: if (rcv) m_mode = 1;
      1: if (!rcv) m_mode = 0;
         else if (edg) begin m_mode = 2; m_align = t; end
      default: begin
        if (!rcv) begin
          m_mode = 0; m_cnt = 0;
        end else begin
          if (exp_se && !stf) begin
            m_cnt++;
            if (m_cnt == BPB) begin m_cnt = 0; nb = 1'b1; end
          end
          if (EN && edg) m_align = t;
        end
      end
    endcase
    m_bpend = nb;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic pkt(input int len, input int e0, input int e1, input int st, input int drop);
    shift_q.delete(); byte_q.delete(); base = t; obs_max = 0;
    for (int c = 0; c < len; c++)
      cyc(!(drop >= 0 && c >= drop), (c == e0) || (c == e1), c == st);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rcving = 1'b0; bus.d_edge = 1'b0; bus.stuff_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_shift", {31'd0, bus.shift_enable}, 32'd0);
    check("reset_byte", {31'd0, bus.byte_received}, 32'd0);
    check("reset_count", 32'(bus.bit_count), 32'd0);
    n_rst = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Plain byte: edge at relative 2 -> shifts 6,14,..,62; byte pulse at 63 only
    pkt(68, 2, -1, -1, -1);
    check("s1_first_shift", 32'(shift_q[0]), 32'd6);
    check("s1_eighth_shift", 32'(shift_q[7]), 32'd62);
    check("s1_byte_count", 32'(byte_q.size()), 32'd1);
    check("s1_byte_time", 32'(byte_q[0]), 32'd63);

    // Stuffed third bit delays the byte by one bit period
    pkt(75, 2, -1, 22, -1);
    check("s2_byte_count", 32'(byte_q.size()), 32'd1);
    check("s2_byte_time", 32'(byte_q[0]), 32'd71);
    check("s2_count_le8", {31'd0, obs_max <= BPB}, 32'd1);

    // rcving drops after five counted bits
    pkt(60, 2, -1, -1, 42);
    check("s3_shifts", 32'(shift_q.size()), 32'd5);
    check("s3_no_byte", 32'(byte_q.size()), 32'd0);

    // Extra edge at phase 6
    pkt(30, 2, 17, -1, -1);
    check("s4_third_shift", 32'(shift_q[2]), EN ? 32'd21 : 32'd22);

    // rcving drops on the eighth shift, then a clean packet counts from zero
    pkt(68, 2, -1, -1, 62);
    check("s5_no_byte", 32'(byte_q.size()), 32'd0);
    pkt(68, 2, -1, -1, -1);
    check("s5_next_byte", 32'(byte_q.size()), 32'd1);
    check("s5_next_time", 32'(byte_q[0]), 32'd63);

    // Async reset mid-RUN clears outputs without waiting for a clock
    base = t;
    for (int c = 0; c < 36; c++) cyc(1'b1, c == 2, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_mid_shift", {31'd0, bus.shift_enable}, 32'd0);
    check("rst_mid_byte", {31'd0, bus.byte_received}, 32'd0);
    check("rst_mid_count", 32'(bus.bit_count), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    t++;
    model_reset();
    shift_q.delete();
    for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, 1'b0);
    check("rst_no_shift", 32'(shift_q.size()), 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Randomised packets: sparse line edges, random stuffed bits, rcving drop at the end
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(40, 160);
      base = t;
      for (int c = 0; c < len; c++)
        cyc(c < len - 1, (c == 1) || ($urandom_range(0, 15) == 0), $urandom_range(0, 5) == 0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
